regfile_mp: RTL and testbench

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard. Provides NRD combinational read ports and two write ports: W0 for the ALU/writeback stage and W1 for the load/late writeback stage. Register 0 reads as zero and can never be written or marked busy. It sits in the decode/writeback boundary of the pipelined CPU and replaces the single-write, two-read register file.

---
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports
// (W1 has priority), optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NRD*AW-1:0] RAdr,
    output logic [NRD*XLEN-1:0] RData,
    output logic [NRD-1:0]    RBusy,
    input  logic              W0En,
    input  logic              W1En,
    input  logic [AW-1:0]     W0Adr,
    input  logic [AW-1:0]     W1Adr,
    input  logic [XLEN-1:0]   W0Din,
    input  logic [XLEN-1:0]   W1Din,
    input  logic              IssueEn,
    input  logic [AW-1:0]     IssueAdr,
    output logic [AW:0]       BusyCnt
);

    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    logic w0_ok, w1_ok, iss_ok;

    assign w0_ok  = W0En && (W0Adr != '0);
    assign w1_ok  = W1En && (W1Adr != '0);
    assign iss_ok = IssueEn && (IssueAdr != '0);

    // W1 is applied after W0 so it wins a same-address collision; issue is
    // applied last so a new producer supersedes the one completing this cycle.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        if (w0_ok) begin
            rf_d[W0Adr]   = W0Din;
            busy_d[W0Adr] = 1'b0;
        end
        if (w1_ok) begin
            rf_d[W1Adr]   = W1Din;
            busy_d[W1Adr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[IssueAdr] = 1'b1;
        end
        rf_d[0]   = '0;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign BusyCnt = cnt_q;

    // Entry 0 of both arrays is held at zero, so address 0 needs no special
    // case on the array path; the bypass hits still exclude it explicitly.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] arr_val;

        assign ra      = RAdr[k*AW +: AW];
        assign arr_val = rf_q[ra];

        if (BYPASS != 0) begin : g_byp
            logic hit0, hit1;

            // Qualified with RST_N so outputs read zero throughout reset even
            // if a write is being presented.
            assign hit0 = RST_N && W0En && (W0Adr == ra) && (ra != '0);
            assign hit1 = RST_N && W1En && (W1Adr == ra) && (ra != '0);

            assign RData[k*XLEN +: XLEN] = hit1 ? W1Din :
                                           hit0 ? W0Din : arr_val;
            assign RBusy[k] = busy_q[ra] && !(hit0 || hit1);
        end else begin : g_nobyp
            assign RData[k*XLEN +: XLEN] = arr_val;
            assign RBusy[k]              = busy_q[ra];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus and are
// checked against a directed vector table and an array-based reference model.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NREG = 32;

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic [NRD*AW-1:0]   RAdr;
    logic                W0En, W1En, IssueEn;
    logic [AW-1:0]       W0Adr, W1Adr, IssueAdr;
    logic [XLEN-1:0]     W0Din, W1Din;

    logic [NRD*XLEN-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic [AW:0]         cnt_b, cnt_n;

    regfile_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(1)) dut_byp (
        .CLK(CLK), .RST_N(RST_N), .RAdr(RAdr), .RData(rdata_b), .RBusy(rbusy_b),
        .W0En(W0En), .W1En(W1En), .W0Adr(W0Adr), .W1Adr(W1Adr),
        .W0Din(W0Din), .W1Din(W1Din), .IssueEn(IssueEn), .IssueAdr(IssueAdr),
        .BusyCnt(cnt_b)
    );

    regfile_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(0)) dut_nobyp (
        .CLK(CLK), .RST_N(RST_N), .RAdr(RAdr), .RData(rdata_n), .RBusy(rbusy_n),
        .W0En(W0En), .W1En(W1En), .W0Adr(W0Adr), .W1Adr(W1Adr),
        .W0Din(W0Din), .W1Din(W1Din), .IssueEn(IssueEn), .IssueAdr(IssueAdr),
        .BusyCnt(cnt_n)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register values and busy flags.
    logic [XLEN-1:0] m_rf   [NREG];
    bit              m_busy [NREG];

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int model_busy_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    // State after a rising edge, applied in program order: W0, W1 (overrides), then issue.
    task automatic model_edge();
        if (W0En && W0Adr != 0) begin m_rf[W0Adr] = W0Din; m_busy[W0Adr] = 1'b0; end
        if (W1En && W1Adr != 0) begin m_rf[W1Adr] = W1Din; m_busy[W1Adr] = 1'b0; end
        if (IssueEn && IssueAdr != 0) m_busy[IssueAdr] = 1'b1;
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < NRD; k++) begin
            int a;
            bit fwd;
            logic [XLEN-1:0] v;
            a   = int'(RAdr[k*AW +: AW]);
            fwd = (a != 0) && ((W1En && W1Adr == a) || (W0En && W0Adr == a));
            if (a == 0)                    v = '0;
            else if (W1En && W1Adr == a)   v = W1Din;
            else if (W0En && W0Adr == a)   v = W0Din;
            else                           v = m_rf[a];
            exp_q.push_back(v);
            exp_q.push_back(m_rf[a]);
            exp_q.push_back({31'b0, m_busy[a] && !fwd});
            exp_q.push_back({31'b0, m_busy[a]});
            chk({tag, "_rdata_byp"},   rdata_b[k*XLEN +: XLEN], exp_q.pop_front());
            chk({tag, "_rdata_nobyp"}, rdata_n[k*XLEN +: XLEN], exp_q.pop_front());
            chk({tag, "_rbusy_byp"},   {31'b0, rbusy_b[k]},     exp_q.pop_front());
            chk({tag, "_rbusy_nobyp"}, {31'b0, rbusy_n[k]},     exp_q.pop_front());
        end
        chk({tag, "_cnt_byp"},   {26'b0, cnt_b}, model_busy_count());
        chk({tag, "_cnt_nobyp"}, {26'b0, cnt_n}, model_busy_count());
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic w0e, input logic [AW-1:0] w0a, input logic [XLEN-1:0] w0d,
                         input logic w1e, input logic [AW-1:0] w1a, input logic [XLEN-1:0] w1d,
                         input logic ie, input logic [AW-1:0] ia,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        W0En = w0e; W0Adr = w0a; W0Din = w0d;
        W1En = w1e; W1Adr = w1a; W1Din = w1d;
        IssueEn = ie; IssueAdr = ia;
        RAdr = {r1, r0};
    endtask

    task automatic cycle(input string tag);
        @(negedge CLK);
        check_model(tag);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    // ---------------- directed vector table (expectations for the BYPASS=1 instance) ----------------
    typedef struct {
        logic            w0e; logic [AW-1:0] w0a; logic [XLEN-1:0] w0d;
        logic            w1e; logic [AW-1:0] w1a; logic [XLEN-1:0] w1d;
        logic            ie;  logic [AW-1:0] ia;
        logic [AW-1:0]   r0;  logic [AW-1:0] r1;
        logic [XLEN-1:0] e_d0; logic [XLEN-1:0] e_d1;
        logic [1:0]      e_busy;
        logic [AW:0]     e_cnt;
    } vec_t;

    vec_t vt [14];

    initial begin
        vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0};
        vt[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0};
        vt[2]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 2'b00, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 2'b00, 0};
        vt[4]  = '{1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7, 32'h22, 32'h22, 2'b00, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 5, 32'h22, 32'hDEADBEEF, 2'b00, 0};
        vt[6]  = '{0, 0, 0, 0, 0, 0, 1, 3, 3, 7, 0, 32'h22, 2'b00, 0};
        vt[7]  = '{0, 0, 0, 1, 3, 32'hABCD, 0, 0, 3, 3, 32'hABCD, 32'hABCD, 2'b00, 1};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'hABCD, 0, 2'b00, 0};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 0, 0, 2'b00, 0};
        vt[10] = '{1, 9, 32'h55, 0, 0, 0, 1, 9, 9, 3, 32'h55, 32'hABCD, 2'b00, 1};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h55, 32'h55, 2'b11, 1};
        vt[12] = '{0, 0, 0, 1, 9, 32'h66, 0, 0, 9, 5, 32'h66, 32'hDEADBEEF, 2'b00, 1};
        vt[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 5, 32'h66, 32'hDEADBEEF, 2'b00, 0};
    end

    // ---------------- test sequence ----------------
    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("reset_cnt", {26'b0, cnt_b}, 0);
        chk("reset_rbusy", {30'b0, rbusy_b}, 0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].w0e, vt[i].w0a, vt[i].w0d, vt[i].w1e, vt[i].w1a, vt[i].w1d,
                  vt[i].ie, vt[i].ia, vt[i].r0, vt[i].r1);
            @(negedge CLK);
            chk($sformatf("vec%0d_d0", i), rdata_b[XLEN-1:0], vt[i].e_d0);
            chk($sformatf("vec%0d_d1", i), rdata_b[2*XLEN-1:XLEN], vt[i].e_d1);
            chk($sformatf("vec%0d_busy", i), {30'b0, rbusy_b}, {30'b0, vt[i].e_busy});
            chk($sformatf("vec%0d_cnt", i), {26'b0, cnt_b}, {26'b0, vt[i].e_cnt});
            check_model($sformatf("vec%0d", i));
            @(posedge CLK);
            model_edge();
            #1;
        end

        // Non-bypass view of a completing write: old data and still busy.
        drive(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
        cycle("nb_issue");
        drive(0, 0, 0, 1, 12, 32'h1234, 0, 0, 12, 0);
        @(negedge CLK);
        chk("nb_old_data", rdata_n[XLEN-1:0], 0);
        chk("nb_still_busy", {31'b0, rbusy_n[0]}, 1);
        chk("byp_fwd_data", rdata_b[XLEN-1:0], 32'h1234);
        check_model("nb_write");
        @(posedge CLK);
        model_edge();
        #1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG-1)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG-1)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG-1)),
                  AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1)));
            if (n % 7 == 0) W1Adr = W0Adr;
            if (n % 5 == 0) RAdr[AW-1:0] = W0Adr;
            cycle("rand");
        end

        // Fill x1..x31 busy and nonzero (write + issue same register each cycle).
        for (int a = 1; a < NREG; a++) begin
            drive(1, AW'(a), 32'h0101_0101 * a, 0, 0, 0, 1, AW'(a), AW'(a), 0);
            cycle("fill");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 31, 1);
        @(negedge CLK);
        chk("fill_cnt", {26'b0, cnt_b}, 31);
        chk("fill_busy", {30'b0, rbusy_b}, 2'b11);
        check_model("fill_idle");
        @(posedge CLK);
        model_edge();

        // Asynchronous reset between edges, with a write presented during reset.
        #3;
        RST_N = 1'b0;
        drive(0, 0, 0, 1, 4, 32'h1234, 1, 6, 4, 4);
        model_reset();
        #1;
        for (int a = 0; a < NREG; a++) begin
            RAdr = {AW'(a), AW'(NREG-1-a)};
            #1;
            chk("arst_rdata_byp", rdata_b[XLEN-1:0] | rdata_b[2*XLEN-1:XLEN], 0);
            chk("arst_rdata_nobyp", rdata_n[XLEN-1:0] | rdata_n[2*XLEN-1:XLEN], 0);
            chk("arst_rbusy", {30'b0, rbusy_b | rbusy_n}, 0);
            chk("arst_cnt", {26'b0, cnt_b | cnt_n}, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 6);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("post_rst_x4", rdata_b[XLEN-1:0], 0);
        chk("post_rst_busy6", {31'b0, rbusy_b[1]}, 0);
        check_model("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
